// File: rtl/decoder_pkg.sv
// Shared definitions for the decoder select-scan logic: select width, last code and FSM encoding.
package decoder_pkg;

  localparam int unsigned SEL_W = 3;
  localparam logic [SEL_W-1:0] SEL_MAX = 3'd7;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_e;

endpackage : decoder_pkg

// File: rtl/dwell_timer.sv
// Reloadable down-counter; flags expiry once the count reaches zero and never underflows.
module dwell_timer #(
  parameter int unsigned DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] load_val_i,
  input  logic               dec_i,
  output logic               expired_o
);

  logic [DWELL_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DWELL_W'(1);
    end
  end

  // Pure decode of the count register, so no input-to-output path exists.
  assign expired_o = (cnt_q == '0);

endmodule : dwell_timer

// File: rtl/decoder_scan_ctrl.sv
// Steps a 3-bit decoder select through 0..7, holding each code for a latched dwell,
// in single-pass or continuous mode with busy/wrap/done reporting.
module decoder_scan_ctrl #(
  parameter int unsigned DWELL_W = 8,
  parameter int unsigned SEL_W   = decoder_pkg::SEL_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               continuous,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   sel,
  output logic               sel_valid,
  output logic               busy,
  output logic               wrap,
  output logic               done
);

  import decoder_pkg::*;

  state_e             state_q;
  logic [SEL_W-1:0]   sel_q;
  logic               cont_q;
  logic [DWELL_W-1:0] reload_q;
  logic               wrap_q;
  logic               done_q;

  logic               expired_c;
  logic               accept_c;
  logic               last_code_c;
  logic               advance_c;
  logic               finish_c;
  logic               tmr_clr_c;
  logic               tmr_load_c;
  logic               tmr_dec_c;
  logic [DWELL_W-1:0] dwell_m1_c;
  logic [DWELL_W-1:0] tmr_val_c;

  // Effective dwell minus one; a programmed 0 behaves as 1.
  assign dwell_m1_c  = (dwell == '0) ? '0 : (dwell - DWELL_W'(1));

  assign accept_c    = (state_q == IDLE) && start && !stop;
  assign last_code_c = (sel_q == SEL_W'(SEL_MAX));
  assign advance_c   = (state_q == SCAN) && !stop && expired_c && (!last_code_c || cont_q);
  assign finish_c    = (state_q == SCAN) && !stop && expired_c && last_code_c && !cont_q;

  assign tmr_clr_c   = ((state_q == SCAN) && stop) || finish_c;
  assign tmr_load_c  = accept_c || advance_c;
  assign tmr_val_c   = (state_q == IDLE) ? dwell_m1_c : reload_q;
  assign tmr_dec_c   = (state_q == SCAN) && !stop;

  dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr_i      (tmr_clr_c),
    .load_i     (tmr_load_c),
    .load_val_i (tmr_val_c),
    .dec_i      (tmr_dec_c),
    .expired_o  (expired_c)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= '0;
      cont_q   <= 1'b0;
      reload_q <= '0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          sel_q <= '0;
          if (accept_c) begin
            state_q  <= SCAN;
            cont_q   <= continuous;
            reload_q <= dwell_m1_c;
          end
        end
        SCAN: begin
          // stop outranks both natural completion and wrap.
          if (stop) begin
            state_q <= IDLE;
            sel_q   <= '0;
          end else if (expired_c) begin
            if (!last_code_c) begin
              sel_q <= sel_q + SEL_W'(1);
            end else if (cont_q) begin
              sel_q  <= '0;
              wrap_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              sel_q   <= '0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          sel_q   <= '0;
        end
      endcase
    end
  end

  assign sel       = sel_q;
  assign sel_valid = (state_q == SCAN);
  assign busy      = (state_q == SCAN);
  assign wrap      = wrap_q;
  assign done      = done_q;

endmodule : decoder_scan_ctrl

// File: tb/tb_decoder_scan_ctrl.sv
// Directed bench for decoder_scan_ctrl; observed word is {sel, sel_valid, busy, wrap, done}.
module tb_decoder_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       stop;
  logic       continuous;
  logic [7:0] dwell;
  logic [2:0] sel;
  logic       sel_valid;
  logic       busy;
  logic       wrap;
  logic       done;

  int n_cmp = 0;
  int n_err = 0;

  logic [6:0] obs;
  logic [6:0] exp_v;

  assign obs = {sel, sel_valid, busy, wrap, done};

  always #5 clk = ~clk;

  decoder_scan_ctrl #(
    .DWELL_W (8),
    .SEL_W   (3)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .continuous (continuous),
    .dwell      (dwell),
    .sel        (sel),
    .sel_valid  (sel_valid),
    .busy       (busy),
    .wrap       (wrap),
    .done       (done)
  );

  // One rising edge, then settle so outputs are read away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; stop = 1'b0; continuous = 1'b0; dwell = 8'd0;
    step();
    step();
    exp_v = 7'b000_0000;
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL reset: got %b want %b", obs, exp_v);
    end
    rst_n = 1'b1;
    step();
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL reset_idle: got %b want %b", obs, exp_v);
    end
  endtask

  // Single pass, dwell=2; a stray start at cycle 3 must be ignored.
  task automatic test_single_dwell2();
    start = 1'b1; continuous = 1'b0; dwell = 8'd2;
    step();
    start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      exp_v = {3'(i / 2), 1'b1, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL single2[%0d]: got %b want %b", i, obs, exp_v);
      end
      start = (i == 3);
      step();
    end
    start = 1'b0;
    exp_v = 7'b000_0001;
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL single2_done: got %b want %b", obs, exp_v);
    end
    step();
    exp_v = 7'b000_0000;
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL single2_after: got %b want %b", obs, exp_v);
    end
  endtask

  task automatic test_dwell_zero();
    start = 1'b1; continuous = 1'b0; dwell = 8'd0;
    step();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      exp_v = {3'(i), 1'b1, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL dwell0[%0d]: got %b want %b", i, obs, exp_v);
      end
      step();
    end
    exp_v = 7'b000_0001;
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL dwell0_done: got %b want %b", obs, exp_v);
    end
    step();
  endtask

  // Continuous, dwell=1; mid-scan mode/dwell changes must have no effect; stop at code 5 of pass 3.
  task automatic test_continuous();
    start = 1'b1; continuous = 1'b1; dwell = 8'd1;
    step();
    start = 1'b0; continuous = 1'b0; dwell = 8'd5;
    for (int i = 0; i < 22; i++) begin
      exp_v = {3'(i % 8), 1'b1, 1'b1, ((i % 8) == 0) && (i > 0), 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL cont[%0d]: got %b want %b", i, obs, exp_v);
      end
      if (i == 21) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    exp_v = 7'b000_0000;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL cont_stop[%0d]: got %b want %b", i, obs, exp_v);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_scan();
    start = 1'b1; continuous = 1'b0; dwell = 8'd3;
    step();
    start = 1'b0;
    for (int i = 0; i < 14; i++) begin
      exp_v = {3'(i / 3), 1'b1, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL rstmid[%0d]: got %b want %b", i, obs, exp_v);
      end
      if (i == 13) rst_n = 1'b0;
      step();
    end
    rst_n = 1'b1;
    exp_v = 7'b000_0000;
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL rstmid_reset: got %b want %b", obs, exp_v);
    end
    step();
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL rstmid_idle: got %b want %b", obs, exp_v);
    end
  endtask

  task automatic test_start_stop_idle();
    start = 1'b1; stop = 1'b1; continuous = 1'b0; dwell = 8'd1;
    step();
    step();
    start = 1'b0; stop = 1'b0;
    exp_v = 7'b000_0000;
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL startstop: got %b want %b", obs, exp_v);
    end
  endtask

  // stop on the last cycle of code 7: no done (single) and no wrap (continuous).
  task automatic test_stop_last();
    for (int m = 0; m < 2; m++) begin
      start = 1'b1; continuous = (m == 1); dwell = 8'd2;
      step();
      start = 1'b0;
      for (int i = 0; i < 16; i++) begin
        exp_v = {3'(i / 2), 1'b1, 1'b1, 1'b0, 1'b0};
        n_cmp++;
        if (obs !== exp_v) begin
          n_err++; $display("FAIL stoplast%0d[%0d]: got %b want %b", m, i, obs, exp_v);
        end
        if (i == 15) stop = 1'b1;
        step();
      end
      stop = 1'b0;
      exp_v = 7'b000_0000;
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL stoplast%0d_end: got %b want %b", m, obs, exp_v);
      end
      step();
    end
  endtask

  // start held high: the second pass begins the cycle after done.
  task automatic test_back_to_back();
    start = 1'b1; continuous = 1'b0; dwell = 8'd2;
    step();
    for (int i = 0; i < 16; i++) begin
      exp_v = {3'(i / 2), 1'b1, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL b2b[%0d]: got %b want %b", i, obs, exp_v);
      end
      step();
    end
    exp_v = 7'b000_0001;
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL b2b_done: got %b want %b", obs, exp_v);
    end
    step();
    for (int i = 0; i < 3; i++) begin
      exp_v = {3'(i / 2), 1'b1, 1'b1, 1'b0, 1'b0};
      n_cmp++;
      if (obs !== exp_v) begin
        n_err++; $display("FAIL b2b_pass2[%0d]: got %b want %b", i, obs, exp_v);
      end
      step();
    end
    start = 1'b0; stop = 1'b1;
    step();
    stop = 1'b0;
    exp_v = 7'b000_0000;
    n_cmp++;
    if (obs !== exp_v) begin
      n_err++; $display("FAIL b2b_stop: got %b want %b", obs, exp_v);
    end
  endtask

  initial begin
    test_reset();
    test_single_dwell2();
    test_dwell_zero();
    test_continuous();
    test_reset_mid_scan();
    test_start_stop_idle();
    test_stop_last();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_decoder_scan_ctrl
